// File: rtl/change_dispenser.sv
// Pays an owed amount (nickel units) as greedy quarter/dime/nickel pulses from a refillable inventory.
// First pulse two cycles after start; optional running payout total under DISPENSE_TOTAL_EN.
module change_dispenser #(
    parameter int AMOUNT_W      = 8,
    parameter int INV_W         = 6,
    parameter int GAP_CYCLES    = 1,
    parameter int INIT_QUARTERS = 10,
    parameter int INIT_DIMES    = 10,
    parameter int INIT_NICKELS  = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] changeNickels,
    input  logic                clearError,
    input  logic                refillValid,
    input  logic [1:0]          refillCoin,
    output logic                dispenseFive,
    output logic                dispenseTen,
    output logic                dispenseTwentyFive,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [AMOUNT_W-1:0] remaining,
    output logic [INV_W-1:0]    quarterCount,
    output logic [INV_W-1:0]    dimeCount,
    output logic [INV_W-1:0]    nickelCount
`ifdef DISPENSE_TOTAL_EN
    ,
    output logic [15:0]         totalDispensed
`endif
);

    localparam logic [1:0] COIN_N = 2'b00;
    localparam logic [1:0] COIN_D = 2'b01;
    localparam logic [1:0] COIN_Q = 2'b10;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [INV_W-1:0] INV_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE, S_ERROR} state_t;

    state_t              state_q;
    logic [AMOUNT_W-1:0] remaining_q;
    logic [1:0]          coin_q;
    logic [GW-1:0]       gap_q;
    logic                nickel_q, dime_q, quarter_q;
    logic                busy_q, done_q, error_q;
    logic [INV_W-1:0]    q_cnt_q, d_cnt_q, n_cnt_q;
    logic [INV_W-1:0]    q_cnt_d, d_cnt_d, n_cnt_d;
    logic                refill_q, refill_d, refill_n;
    logic                take_q, take_d, take_n;
    logic [AMOUNT_W-1:0] coin_val, rem_after;
    logic                use_q, use_d, use_n;

    // Simultaneous refill and payout of the same coin cancel out.
    function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        inv_next = cnt;
        if (inc && !dec && cnt != INV_MAX)
            inv_next = cnt + INV_W'(1);
        else if (dec && !inc)
            inv_next = cnt - INV_W'(1);
    endfunction

    always_comb begin
        refill_q = refillValid && (refillCoin == COIN_Q);
        refill_d = refillValid && (refillCoin == COIN_D);
        refill_n = refillValid && (refillCoin == COIN_N);
        take_q   = (state_q == S_PULSE) && (coin_q == COIN_Q);
        take_d   = (state_q == S_PULSE) && (coin_q == COIN_D);
        take_n   = (state_q == S_PULSE) && (coin_q == COIN_N);
        q_cnt_d  = inv_next(q_cnt_q, refill_q, take_q);
        d_cnt_d  = inv_next(d_cnt_q, refill_d, take_d);
        n_cnt_d  = inv_next(n_cnt_q, refill_n, take_n);
        case (coin_q)
            COIN_Q:  coin_val = AMOUNT_W'(5);
            COIN_D:  coin_val = AMOUNT_W'(2);
            default: coin_val = AMOUNT_W'(1);
        endcase
        rem_after = remaining_q - coin_val;
        // A refill arriving during SELECT counts toward availability.
        use_q = (remaining_q >= AMOUNT_W'(5)) && ((q_cnt_q != '0) || refill_q);
        use_d = (remaining_q >= AMOUNT_W'(2)) && ((d_cnt_q != '0) || refill_d);
        use_n = (n_cnt_q != '0) || refill_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_cnt_q <= INV_W'(INIT_QUARTERS);
            d_cnt_q <= INV_W'(INIT_DIMES);
            n_cnt_q <= INV_W'(INIT_NICKELS);
        end else begin
            q_cnt_q <= q_cnt_d;
            d_cnt_q <= d_cnt_d;
            n_cnt_q <= n_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            coin_q      <= COIN_N;
            gap_q       <= '0;
            nickel_q    <= 1'b0;
            dime_q      <= 1'b0;
            quarter_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            nickel_q  <= 1'b0;
            dime_q    <= 1'b0;
            quarter_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        remaining_q <= changeNickels;
                        busy_q      <= 1'b1;
                        if (changeNickels == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (use_q) begin
                        coin_q    <= COIN_Q;
                        quarter_q <= 1'b1;
                        state_q   <= S_PULSE;
                    end else if (use_d) begin
                        coin_q  <= COIN_D;
                        dime_q  <= 1'b1;
                        state_q <= S_PULSE;
                    end else if (use_n) begin
                        coin_q   <= COIN_N;
                        nickel_q <= 1'b1;
                        state_q  <= S_PULSE;
                    end else begin
                        error_q <= 1'b1;
                        state_q <= S_ERROR;
                    end
                end
                S_PULSE: begin
                    remaining_q <= rem_after;
                    if (rem_after == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        gap_q   <= GAP_LAST;
                        state_q <= S_GAP;
                    end else begin
                        state_q <= S_SELECT;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0)
                        state_q <= S_SELECT;
                    else
                        gap_q <= gap_q - GW'(1);
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERROR: begin
                    if (clearError) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    error_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DISPENSE_TOTAL_EN
    logic [15:0] total_q;

    always_ff @(posedge clock) begin
        if (reset)
            total_q <= '0;
        else if (state_q == S_PULSE)
            total_q <= total_q + 16'(coin_val);
    end

    assign totalDispensed = total_q;
`endif

    assign dispenseFive       = nickel_q;
    assign dispenseTen        = dime_q;
    assign dispenseTwentyFive = quarter_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign remaining          = remaining_q;
    assign quarterCount       = q_cnt_q;
    assign dimeCount          = d_cnt_q;
    assign nickelCount        = n_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with default parameters (GAP_CYCLES = 1).
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] changeNickels = '0;
    logic       clearError = 1'b0;
    logic       refillValid = 1'b0;
    logic [1:0] refillCoin = 2'b00;
    logic       dispenseFive, dispenseTen, dispenseTwentyFive;
    logic       busy, done, error;
    logic [7:0] remaining;
    logic [5:0] quarterCount, dimeCount, nickelCount;
`ifdef DISPENSE_TOTAL_EN
    logic [15:0] totalDispensed;
`endif

    change_dispenser dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .changeNickels      (changeNickels),
        .clearError         (clearError),
        .refillValid        (refillValid),
        .refillCoin         (refillCoin),
        .dispenseFive       (dispenseFive),
        .dispenseTen        (dispenseTen),
        .dispenseTwentyFive (dispenseTwentyFive),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .remaining          (remaining),
        .quarterCount       (quarterCount),
        .dimeCount          (dimeCount),
        .nickelCount        (nickelCount)
`ifdef DISPENSE_TOTAL_EN
        ,
        .totalDispensed     (totalDispensed)
`endif
    );

    always #5 clock = ~clock;

    localparam logic [2:0] P_Q = 3'b100;
    localparam logic [2:0] P_D = 3'b010;
    localparam logic [2:0] P_N = 3'b001;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] pulse_codes[$];
    int         pulse_cyc[$];
    int         end_cyc;
    logic       ended_err;
    logic       bad_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] code_at(input int i);
        return (i < pulse_codes.size()) ? 32'(pulse_codes[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] cyc_at(input int i);
        return (i < pulse_cyc.size()) ? 32'(pulse_cyc[i]) : 32'hFFFF_FFFF;
    endfunction

    // Starts a payout from IDLE and logs every pulse by cycle (1 = cycle after start accepted)
    // until done or error; finishes one cycle later so the block is back in IDLE (or still ERROR).
    task automatic pay(input logic [7:0] amt, input int max_cyc);
        logic [2:0] code;
        logic       prev;
        pulse_codes.delete();
        pulse_cyc.delete();
        end_cyc   = -1;
        ended_err = 1'b0;
        bad_pulse = 1'b0;
        prev      = 1'b0;
        changeNickels = amt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            code = {dispenseTwentyFive, dispenseTen, dispenseFive};
            if (code != 3'b000) begin
                pulse_codes.push_back(code);
                pulse_cyc.push_back(c);
                if ($countones(code) != 1 || prev) bad_pulse = 1'b1;
            end
            prev = (code != 3'b000);
            if (done || error) begin
                end_cyc   = c;
                ended_err = error;
                break;
            end
            tick();
        end
        check("pay_terminates", 32'(end_cyc > 0), 1);
        check("pulse_onehot_gapped", 32'(bad_pulse), 0);
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done_err", 32'({done, error}), 0);
        check("rst_pulses", 32'({dispenseTwentyFive, dispenseTen, dispenseFive}), 0);
        check("rst_remaining", 32'(remaining), 0);
        check("rst_inv", 32'({quarterCount, dimeCount, nickelCount}), 32'({6'd10, 6'd10, 6'd10}));
        reset = 1'b0;
        tick();

        // One quarter: pulse in k+2, done in k+3.
        pay(8'd5, 20);
        check("p5_count", 32'(pulse_codes.size()), 1);
        check("p5_coin", code_at(0), 32'(P_Q));
        check("p5_pulse_cyc", cyc_at(0), 2);
        check("p5_done_cyc", 32'(end_cyc), 3);
        check("p5_quarters", 32'(quarterCount), 9);
        check("p5_idle_busy", 32'(busy), 0);

        // 40 cents: quarter, dime, nickel with one gap cycle between.
        pay(8'd8, 30);
        check("p8_count", 32'(pulse_codes.size()), 3);
        check("p8_coin0", code_at(0), 32'(P_Q));
        check("p8_coin1", code_at(1), 32'(P_D));
        check("p8_coin2", code_at(2), 32'(P_N));
        check("p8_cyc1", cyc_at(1), 5);
        check("p8_cyc2", cyc_at(2), 8);
        check("p8_done_cyc", 32'(end_cyc), 9);
        check("p8_remaining", 32'(remaining), 0);
        check("p8_inv", 32'({quarterCount, dimeCount, nickelCount}), 32'({6'd8, 6'd9, 6'd9}));

        // Drain all eight quarters, then 25 cents must come out as dime, dime, nickel.
        pay(8'd40, 80);
        check("p40_count", 32'(pulse_codes.size()), 8);
        check("p40_quarters", 32'(quarterCount), 0);
        pay(8'd5, 30);
        check("noq_count", 32'(pulse_codes.size()), 3);
        check("noq_coin0", code_at(0), 32'(P_D));
        check("noq_coin1", code_at(1), 32'(P_D));
        check("noq_coin2", code_at(2), 32'(P_N));
        check("noq_inv", 32'({quarterCount, dimeCount, nickelCount}), 32'({6'd0, 6'd7, 6'd8}));

        // Drain nickels; 15 cents then pays one dime and errors with 1 still owed.
        for (int i = 0; i < 8; i++) pay(8'd1, 10);
        check("drain_nickels", 32'(nickelCount), 0);
        pay(8'd3, 30);
        check("err_count", 32'(pulse_codes.size()), 1);
        check("err_coin", code_at(0), 32'(P_D));
        check("err_end_cyc", 32'(end_cyc), 5);
        check("err_flag", 32'({error, busy}), 32'(2'b11));
        check("err_remaining", 32'(remaining), 1);
        check("err_dimes", 32'(dimeCount), 6);
        changeNickels = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("err_ignores_start", 32'({error, remaining}), 32'({1'b1, 8'd1}));
        clearError = 1'b1;
        tick();
        clearError = 1'b0;
        check("clr_idle", 32'({busy, error}), 0);

        // Refill: coin code 11 ignored, refill + payout of the same coin cancels, saturation at 63.
        refillValid = 1'b1;
        refillCoin  = 2'b10;
        tick();
        tick();
        refillCoin  = 2'b11;
        tick();
        refillValid = 1'b0;
        check("refill_inv", 32'({quarterCount, dimeCount, nickelCount}), 32'({6'd2, 6'd6, 6'd0}));
        changeNickels = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rq_pulse", 32'(dispenseTwentyFive), 1);
        refillValid = 1'b1;
        refillCoin  = 2'b10;
        tick();
        refillValid = 1'b0;
        check("rq_done", 32'(done), 1);
        check("rq_quarters", 32'(quarterCount), 2);
        tick();
        refillValid = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        refillValid = 1'b0;
        check("refill_sat", 32'(quarterCount), 63);

        // Reset during the first gap of a 40-cent payout.
        changeNickels = 8'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rg_pulse", 32'(dispenseTwentyFive), 1);
        tick();
        check("rg_gap", 32'({busy, dispenseTwentyFive, dispenseTen, dispenseFive}), 32'(4'b1000));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rg_idle", 32'({busy, done, error, remaining}), 0);
        check("rg_inv", 32'({quarterCount, dimeCount, nickelCount}), 32'({6'd10, 6'd10, 6'd10}));
        tick();
        tick();
        check("rg_quiet", 32'({busy, dispenseTwentyFive, dispenseTen, dispenseFive}), 0);
        pay(8'd0, 10);
        check("zero_done_cyc", 32'(end_cyc), 1);
        check("zero_pulses", 32'(pulse_codes.size()), 0);
        check("zero_no_err", 32'(ended_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Output side of the vending machine: the coin-accepting FSM takes coins in, and this block pays change out.
- On `start`, latches an owed amount in nickel units and dispenses it as single-cycle coin pulses (quarter, dime, nickel).
- Greedy coin choice, limited by an internal per-coin inventory.
- Inter-coin recovery gap for the solenoids; raises an error if exact change cannot be paid.

Parameters:
- AMOUNT_W, 8, width of the owed amount (units of 5 cents).
- INV_W, 6, width of each coin inventory counter.
- GAP_CYCLES, 1, idle cycles between consecutive pulses (0 allowed).
- INIT_QUARTERS, 10, quarter inventory after reset.
- INIT_DIMES, 10, dime inventory after reset.
- INIT_NICKELS, 10, nickel inventory after reset.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to pay change; sampled only in IDLE.
- changeNickels  in  AMOUNT_W  owed amount (1 = 5c, 2 = 10c, 5 = 25c); latched on accepted start.
- clearError  in  1  acknowledges ERROR; returns the block to IDLE.
- refillValid  in  1  adds one coin to inventory this cycle.
- refillCoin  in  2  00 nickel, 01 dime, 10 quarter, 11 ignored.
- dispenseFive  out  1  one-cycle nickel pulse.
- dispenseTen  out  1  one-cycle dime pulse.
- dispenseTwentyFive  out  1  one-cycle quarter pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  high while in ERROR.
- remaining  out  AMOUNT_W  amount still owed.
- quarterCount, dimeCount, nickelCount  out  INV_W  current inventory.

Behaviour:
- Reset values:
  - state = IDLE.
  - All dispense outputs, busy, done, error = 0; remaining = 0.
  - Inventories = INIT_* values.
  - Reset mid-operation aborts immediately: no further pulses, no refund bookkeeping.
- States: IDLE, SELECT, PULSE, GAP, DONE, ERROR.
- IDLE:
  - start=1: latch changeNickels into remaining.
  - If the value is 0, go to DONE; else go to SELECT.
  - start is ignored in all other states.
- SELECT (1 cycle), priority order:
  - remaining>=5 and quarterCount>0: quarter.
  - Else remaining>=2 and dimeCount>0: dime.
  - Else nickelCount>0: nickel.
  - Else go to ERROR.
  - Greedy only, no backtracking. Example: remaining 3, dimes present, no nickels → dime, then ERROR with remaining 1.
- PULSE (1 cycle):
  - Exactly one dispense output is high.
  - At the end of the cycle, the chosen inventory and remaining decrement by the coin value (5/2/1).
  - New remaining == 0: go to DONE.
  - Else GAP_CYCLES>0: go to GAP.
  - Else go to SELECT.
- GAP: holds exactly GAP_CYCLES cycles, all outputs low except busy, then goes to SELECT.
- DONE: done=1 for one cycle, then IDLE.
- ERROR:
  - error=1 and remaining hold their values.
  - Stays until clearError=1, then IDLE on the next cycle.
  - Coins already paid are not recovered.
- Dispense outputs are one-hot or zero, registered, never high in consecutive cycles when GAP_CYCLES>0.
- Latency: start accepted at edge k → SELECT in cycle k+1 → first pulse in cycle k+2 → done in the cycle after the last pulse.
- Refill:
  - Accepted in any state, including during reset-free operation.
  - Saturates at 2^INV_W-1.
  - Refill and decrement of the same coin in the same cycle leave the count unchanged.
  - A refill visible at SELECT is used for that selection.
- clearError outside ERROR has no effect.

Optional Feature:
- Macro: DISPENSE_TOTAL_EN.
- When defined:
  - Adds output totalDispensed (16 bits, nickel units).
  - Incremented by each pulse's coin value; wraps at 2^16; cleared only by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- changeNickels=5, default inventory, GAP_CYCLES=1 → single dispenseTwentyFive pulse in cycle k+2, done in k+3, quarterCount 10→9.
- changeNickels=8 → pulse order quarter, dime, nickel, each separated by one gap cycle; done after the nickel; remaining 0.
- quarterCount=0, changeNickels=5 → dime, dime, nickel; quarterCount remains 0.
- nickelCount=0, changeNickels=3 → one dime, then error=1 with remaining=1; clearError → IDLE, busy=0.
- refillValid with refillCoin=10 in the same cycle a quarter pulses → quarterCount unchanged; refill at 63 stays 63.
- reset asserted during GAP of an 8-nickel payout → next cycle IDLE, no pulses, inventories back to INIT_*; changeNickels=0 start → done pulse next cycle with no coin pulses.
